// File: rtl/solver_arbiter_if.sv
// Handshake and stream bundle between two requesters, the arbiter and the map solver.
interface solver_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        in_valid0;
    logic        in_valid1;
    logic [2:0]  guy0;
    logic [2:0]  guy1;
    logic [15:0] row0;
    logic [15:0] row1;
    logic        s_in_valid;
    logic [2:0]  s_guy;
    logic [15:0] s_row;
    logic        s_out_valid;
    logic [1:0]  s_out;
    logic        out_valid0;
    logic        out_valid1;
    logic [1:0]  out0;
    logic [1:0]  out1;
    logic        busy;
    logic        err;

    modport master (
        output req, in_valid0, in_valid1, guy0, guy1, row0, row1, s_out_valid, s_out,
        input  gnt, s_in_valid, s_guy, s_row, out_valid0, out_valid1, out0, out1, busy, err
    );

    modport slave (
        input  req, in_valid0, in_valid1, guy0, guy1, row0, row1, s_out_valid, s_out,
        output gnt, s_in_valid, s_guy, s_row, out_valid0, out_valid1, out0, out1, busy, err
    );
endinterface

// File: rtl/solver_arbiter.sv
// Round-robin arbiter sharing one map solver between two requesters: forwards ROWS
// map rows from the granted requester and routes the solver's ROWS-1 moves back.
module solver_arbiter #(
    parameter int ROWS    = 64,
    parameter int TIMEOUT = 3000
) (
    input  logic            clk,
    input  logic            rst,
    solver_arbiter_if.slave bus
);
    localparam int RCW = $clog2(ROWS + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [RCW-1:0] LAST_ROW  = RCW'(ROWS - 1);
    localparam logic [RCW-1:0] MOVES     = RCW'(ROWS - 1);
    localparam logic [TCW-1:0] LAST_IDLE = TCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, DRAIN, DONE, ERR} state_t;

    state_t         state;
    logic           gidx;
    logic           lp;
    logic [RCW-1:0] row_cnt;
    logic [RCW-1:0] mv_cnt;
    logic [TCW-1:0] idle_cnt;

    logic           pick;
    logic           sel_valid;
    logic [2:0]     sel_guy;
    logic [15:0]    sel_row;
    logic           fwd;

    always_comb begin
        pick      = (bus.req == 2'b11) ? ~lp : bus.req[1];
        sel_valid = gidx ? bus.in_valid1 : bus.in_valid0;
        sel_guy   = gidx ? bus.guy1 : bus.guy0;
        sel_row   = gidx ? bus.row1 : bus.row0;
        // A move beyond ROWS-1 is dropped, never routed to the requester.
        fwd = 1'b0;
        if (bus.s_out_valid) begin
            if (state == WAIT)
                fwd = 1'b1;
            else if (state == DRAIN && mv_cnt != MOVES)
                fwd = 1'b1;
        end
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            gidx           <= 1'b0;
            lp             <= 1'b1;
            row_cnt        <= '0;
            mv_cnt         <= '0;
            idle_cnt       <= '0;
            bus.gnt        <= 2'b00;
            bus.err        <= 1'b0;
            bus.s_in_valid <= 1'b0;
            bus.s_guy      <= 3'd0;
            bus.s_row      <= 16'd0;
            bus.out_valid0 <= 1'b0;
            bus.out_valid1 <= 1'b0;
            bus.out0       <= 2'd0;
            bus.out1       <= 2'd0;
        end else begin
            // Stream outputs idle at zero unless a state below forwards a beat.
            bus.s_in_valid <= 1'b0;
            bus.s_guy      <= 3'd0;
            bus.s_row      <= 16'd0;
            bus.out_valid0 <= 1'b0;
            bus.out_valid1 <= 1'b0;
            bus.out0       <= 2'd0;
            bus.out1       <= 2'd0;

            case (state)
                IDLE: begin
                    row_cnt  <= '0;
                    mv_cnt   <= '0;
                    idle_cnt <= '0;
                    if (bus.req != 2'b00) begin
                        gidx    <= pick;
                        bus.gnt <= pick ? 2'b10 : 2'b01;
                        state   <= LOAD;
                    end
                end

                LOAD: begin
                    if (sel_valid) begin
                        bus.s_in_valid <= 1'b1;
                        bus.s_row      <= sel_row;
                        if (row_cnt == '0)
                            bus.s_guy <= sel_guy;
                        row_cnt <= row_cnt + 1'b1;
                        if (row_cnt == LAST_ROW) begin
                            idle_cnt <= '0;
                            state    <= WAIT;
                        end
                    end else if (row_cnt != '0) begin
                        state <= ERR;
                    end else if (idle_cnt == LAST_IDLE) begin
                        state <= ERR;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                WAIT: begin
                    if (bus.s_out_valid) begin
                        mv_cnt <= RCW'(1);
                        state  <= DRAIN;
                    end else if (idle_cnt == LAST_IDLE) begin
                        state <= ERR;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                DRAIN: begin
                    if (bus.s_out_valid) begin
                        if (mv_cnt == MOVES)
                            state <= ERR;
                        else
                            mv_cnt <= mv_cnt + 1'b1;
                    end else begin
                        state <= (mv_cnt == MOVES) ? DONE : ERR;
                    end
                end

                DONE: begin
                    bus.gnt  <= 2'b00;
                    bus.err  <= 1'b0;
                    lp       <= gidx;
                    row_cnt  <= '0;
                    mv_cnt   <= '0;
                    idle_cnt <= '0;
                    state    <= IDLE;
                end

                ERR: begin
                    bus.gnt  <= 2'b00;
                    bus.err  <= 1'b1;
                    lp       <= gidx;
                    row_cnt  <= '0;
                    mv_cnt   <= '0;
                    idle_cnt <= '0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase

            if (fwd) begin
                if (gidx) begin
                    bus.out_valid1 <= 1'b1;
                    bus.out1       <= bus.s_out;
                end else begin
                    bus.out_valid0 <= 1'b1;
                    bus.out0       <= bus.s_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_solver_arbiter.sv
// Randomized bench for solver_arbiter: drives whole runs and compares the observed
// row and move streams against expectations built from the arbitration rules.
module tb_solver_arbiter;
    localparam int ROWS      = 64;
    localparam int TIMEOUT   = 3000;
    localparam int K_CLEAN   = 0;
    localparam int K_DROP    = 1;
    localparam int K_SHORT   = 2;
    localparam int K_LONG    = 3;
    localparam int K_WAIT_TO = 4;
    localparam int K_LOAD_TO = 5;
    localparam int K_RST     = 6;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic lp_m = 1'b1;
    logic err_m = 1'b0;

    logic [63:0] exp_s[$];
    logic [63:0] obs_s[$];
    logic [63:0] exp_o[$];
    logic [63:0] obs_o0[$];
    logic [63:0] obs_o1[$];

    solver_arbiter_if bus();

    solver_arbiter #(.ROWS(ROWS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [29:0] outs();
        return {bus.gnt, bus.busy, bus.err, bus.s_in_valid, bus.s_guy, bus.s_row,
                bus.out_valid0, bus.out_valid1, bus.out0, bus.out1};
    endfunction

    // Record every forwarded beat with the cycle it appeared in.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.s_in_valid) obs_s.push_back({32'(cyc), 13'd0, bus.s_guy, bus.s_row});
            if (bus.out_valid0) obs_o0.push_back({32'(cyc), 30'd0, bus.out0});
            if (bus.out_valid1) obs_o1.push_back({32'(cyc), 30'd0, bus.out1});
            chk("idle_zero", 64'({bus.s_in_valid ? 19'd0 : {bus.s_guy, bus.s_row},
                                  bus.out_valid0 ? 2'd0 : bus.out0,
                                  bus.out_valid1 ? 2'd0 : bus.out1}), 64'd0);
        end
    end

    task automatic clear_q();
        exp_s.delete(); obs_s.delete(); exp_o.delete(); obs_o0.delete(); obs_o1.delete();
    endtask

    // Granted requester is quiet; the other one and the solver output carry noise.
    task automatic idle(input int g);
        if (g == 0) begin
            bus.in_valid0 = 1'b0; bus.guy0 = 3'($urandom); bus.row0 = 16'($urandom);
            bus.in_valid1 = 1'($urandom); bus.guy1 = 3'($urandom); bus.row1 = 16'($urandom);
        end else begin
            bus.in_valid1 = 1'b0; bus.guy1 = 3'($urandom); bus.row1 = 16'($urandom);
            bus.in_valid0 = 1'($urandom); bus.guy0 = 3'($urandom); bus.row0 = 16'($urandom);
        end
        bus.s_out_valid = 1'b0;
        bus.s_out = 2'($urandom);
    endtask

    task automatic step(input int g);
        @(posedge clk);
        #1;
        idle(g);
    endtask

    task automatic set_row(input int g, input logic [2:0] gy, input logic [15:0] rw);
        if (g == 0) begin bus.in_valid0 = 1'b1; bus.guy0 = gy; bus.row0 = rw; end
        else begin bus.in_valid1 = 1'b1; bus.guy1 = gy; bus.row1 = rw; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(outs()), 64'd0);
        rst = 1'b0;
        lp_m = 1'b1;
        err_m = 1'b0;
        clear_q();
    endtask

    task automatic run(input logic [1:0] rq, input int kind, input int drop_at);
        int g, nrows, nmoves, c0, budget;
        logic [2:0] gy;
        logic [15:0] rw;
        logic [1:0] mv;
        bit got;
        g = (rq == 2'b11) ? (lp_m ? 0 : 1) : (rq[1] ? 1 : 0);
        clear_q();
        bus.req = rq;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step(g);
            got = (bus.gnt != 2'b00);
        end
        bus.req = 2'b00;
        chk("gnt", 64'(bus.gnt), (g == 1) ? 64'd2 : 64'd1);
        chk("busy_on_grant", 64'(bus.busy), 64'd1);
        chk("err_held", 64'(bus.err), 64'(err_m));
        c0 = cyc;

        nrows = (kind == K_LOAD_TO) ? 0 : (kind == K_DROP) ? drop_at : ROWS;
        if (nrows > 0) repeat ($urandom_range(0, 6)) step(g);
        for (int r = 0; r < nrows; r++) begin
            gy = 3'($urandom);
            rw = 16'($urandom);
            set_row(g, gy, rw);
            bus.s_out_valid = 1'($urandom);
            exp_s.push_back({32'(cyc + 1), 13'd0, (r == 0) ? gy : 3'd0, rw});
            step(g);
        end
        if (kind == K_WAIT_TO) c0 = cyc;

        if (kind == K_CLEAN || kind == K_SHORT || kind == K_LONG || kind == K_RST) begin
            nmoves = (kind == K_SHORT) ? ROWS - 2 : (kind == K_LONG) ? ROWS : ROWS - 1;
            repeat ($urandom_range(0, 20)) step(g);
            for (int m = 0; m < nmoves; m++) begin
                mv = 2'($urandom);
                bus.s_out_valid = 1'b1;
                bus.s_out = mv;
                if (kind == K_RST && m == 10) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    chk("rst_drain_outputs", 64'(outs()), 64'd0);
                    rst = 1'b0;
                    step(g);
                    bus.s_out_valid = 1'b1;
                    step(g);
                    chk("after_rst_quiet", 64'(outs()), 64'd0);
                    lp_m = 1'b1;
                    err_m = 1'b0;
                    clear_q();
                    return;
                end
                if (m < ROWS - 1) exp_o.push_back({32'(cyc + 1), 30'd0, mv});
                step(g);
            end
        end

        budget = (kind == K_WAIT_TO || kind == K_LOAD_TO) ? TIMEOUT + 20 : 20;
        for (int i = 0; i < budget && bus.busy; i++) step(g);
        chk("run_ends", 64'(bus.busy), 64'd0);
        if (kind == K_WAIT_TO || kind == K_LOAD_TO)
            chk("timeout_len", 64'(cyc - c0), 64'(TIMEOUT + 1));
        err_m = (kind != K_CLEAN);
        lp_m = (g == 1);
        chk("err_after", 64'(bus.err), 64'(err_m));
        chk("gnt_after", 64'(bus.gnt), 64'd0);

        chk("s_in_count", 64'(obs_s.size()), 64'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++)
            chk("s_in_beat", obs_s[i], exp_s[i]);
        if (g == 0) begin
            chk("out0_count", 64'(obs_o0.size()), 64'(exp_o.size()));
            for (int i = 0; i < exp_o.size() && i < obs_o0.size(); i++)
                chk("out0_beat", obs_o0[i], exp_o[i]);
            chk("out1_silent", 64'(obs_o1.size()), 64'd0);
        end else begin
            chk("out1_count", 64'(obs_o1.size()), 64'(exp_o.size()));
            for (int i = 0; i < exp_o.size() && i < obs_o1.size(); i++)
                chk("out1_beat", obs_o1[i], exp_o[i]);
            chk("out0_silent", 64'(obs_o0.size()), 64'd0);
        end
        if (bus.busy) do_reset();
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 2'b00;
        bus.in_valid0 = 1'b0; bus.in_valid1 = 1'b0;
        bus.guy0 = 3'd0; bus.guy1 = 3'd0;
        bus.row0 = 16'd0; bus.row1 = 16'd0;
        bus.s_out_valid = 1'b0; bus.s_out = 2'd0;
        do_reset();
        run(2'b11, K_CLEAN, 0);
        run(2'b11, K_CLEAN, 0);
        run(2'b10, K_DROP, 30);
        run(2'b10, K_CLEAN, 0);
        run(2'b01, K_WAIT_TO, 0);
        run(2'b10, K_SHORT, 0);
        run(2'b11, K_LONG, 0);
        run(2'b01, K_LOAD_TO, 0);
        run(2'b01, K_CLEAN, 0);
        run(2'b11, K_RST, 0);
        run(2'b11, K_CLEAN, 0);
        for (int i = 0; i < 8; i++)
            run(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, ROWS - 1)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
